note_box_drawer: RTL and testbench

//  Rasterises one note-slot box (BOX_W x BOX_H pixels) onto the 160x120 VGA frame buffer, one pixel per clock.

---
 rtl/note_box_drawer.sv | 172 +++++++++++++++++
 tb/tb_note_box_drawer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_box_drawer.sv
// Rasterises one BOX_W x BOX_H note-slot box into the VGA frame buffer, one pixel per clock.
// Border pixels take the latched border colour, interior pixels the latched fill colour.
module note_box_drawer #(
  parameter int BOX_W = 36,
  parameter int BOX_H = 12,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [2:0] fill_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] ax_q, ax_d;
  logic [6:0] ay_q, ay_d;
  logic [2:0] ac_q, ac_d;
  logic [2:0] af_q, af_d;
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic [2:0] pc_q, pc_d;
  logic [2:0] pf_q, pf_d;
  logic       pv_q, pv_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       ovf_q, ovf_d;

  logic       last_col, last_row;
  logic [8:0] xsum;
  logic [7:0] ysum;

  assign last_col = (cx_q == 8'(BOX_W - 1));
  assign last_row = (cy_q == 7'(BOX_H - 1));

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    ac_d    = ac_q;
    af_d    = af_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    pf_d    = pf_q;
    pv_d    = pv_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ax_d    = x_in;
          ay_d    = y_in;
          ac_d    = colour_in;
          af_d    = fill_in;
          cx_d    = '0;
          cy_d    = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (start) begin
          if (!pv_q) begin
            px_d = x_in;
            py_d = y_in;
            pc_d = colour_in;
            pf_d = fill_in;
            pv_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // cx/cy stay on the last pixel so x_out/y_out/colour hold through DONE/IDLE
        if (last_col && last_row) begin
          state_d = DONE;
        end else if (last_col) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      DONE: begin
        if (pv_q) begin
          ax_d    = px_q;
          ay_d    = py_q;
          ac_d    = pc_q;
          af_d    = pf_q;
          cx_d    = '0;
          cy_d    = '0;
          pv_d    = 1'b0;
          state_d = DRAW;
          if (start) begin
            px_d = x_in;
            py_d = y_in;
            pc_d = colour_in;
            pf_d = fill_in;
            pv_d = 1'b1;
          end
        end else if (start) begin
          ax_d    = x_in;
          ay_d    = y_in;
          ac_d    = colour_in;
          af_d    = fill_in;
          cx_d    = '0;
          cy_d    = '0;
          state_d = DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      ac_q    <= '0;
      af_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      pf_q    <= '0;
      pv_q    <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      ac_q    <= ac_d;
      af_q    <= af_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      pf_q    <= pf_d;
      pv_q    <= pv_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clipping uses the unwrapped sums; the visible coordinates are their low bits.
  assign xsum     = {1'b0, ax_q} + {1'b0, cx_q};
  assign ysum     = {1'b0, ay_q} + {1'b0, cy_q};
  assign x_out    = xsum[7:0];
  assign y_out    = ysum[6:0];
  assign colour   = (cx_q == '0 || last_col || cy_q == '0 || last_row) ? ac_q : af_q;
  assign writeEn  = (state_q == DRAW) && (xsum < 9'(SCR_W)) && (ysum < 8'(SCR_H));
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_note_box_drawer.sv
// Bench for note_box_drawer: vector table, corner-case sequences and random requests
// checked cycle by cycle against a request-level model of the box scheduler.
module tb_note_box_drawer;

  localparam int BW = 36;
  localparam int BH = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [2:0] fill_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       writeEn, busy, done, overflow;

  note_box_drawer #(.BOX_W(BW), .BOX_H(BH), .SCR_W(160), .SCR_H(120)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .fill_in(fill_in), .x_out(x_out), .y_out(y_out),
    .colour(colour), .writeEn(writeEn), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int c; int f; } req_t;
  typedef struct { bit we; int x; int y; int col; } pix_t;

  req_t pend_q[$];
  pix_t exp_q[$];
  int   m_rem  = 0;
  bit   m_done = 1'b0;
  bit   m_ovf  = 1'b0;

  function automatic void activate(req_t r);
    pix_t p;
    for (int row = 0; row < BH; row++) begin
      for (int col = 0; col < BW; col++) begin
        p.we  = (r.x + col < 160) && (r.y + row < 120);
        p.x   = (r.x + col) % 256;
        p.y   = (r.y + row) % 128;
        p.col = (row == 0 || row == BH - 1 || col == 0 || col == BW - 1) ? r.c : r.f;
        exp_q.push_back(p);
      end
    end
    m_rem = BW * BH;
  endfunction

  always @(posedge clk) begin
    req_t nr;
    nr.x = int'(x_in); nr.y = int'(y_in); nr.c = int'(colour_in); nr.f = int'(fill_in);
    m_ovf = 1'b0;
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
      m_rem  = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
      if (pend_q.size() != 0) begin
        activate(pend_q.pop_front());
        if (start) pend_q.push_back(nr);
      end else if (start) begin
        activate(nr);
      end
    end else if (m_rem > 0) begin
      if (start) begin
        if (pend_q.size() == 0) pend_q.push_back(nr);
        else m_ovf = 1'b1;
      end
      m_rem--;
      if (m_rem == 0) m_done = 1'b1;
    end else if (start) begin
      activate(nr);
    end
  end

  // ---------------- monitor / checker ----------------
  bit   chk_en = 1'b0;
  int   wcount = 0, dcount = 0, ocount = 0;
  logic [17:0] wlog [512];

  always @(negedge clk) begin
    if (chk_en) begin
      pix_t p;
      chk("busy", busy, 32'(m_rem > 0 || m_done));
      chk("done", done, 32'(m_done));
      chk("overflow", overflow, 32'(m_ovf));
      if (m_rem > 0 && exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("writeEn", writeEn, 32'(p.we));
        if (p.we) begin
          chk("x_out", x_out, p.x);
          chk("y_out", y_out, p.y);
          chk("colour", colour, p.col);
        end
      end else begin
        chk("writeEn_idle", writeEn, 0);
      end
      if (writeEn === 1'b1) begin
        if (wcount < 512) wlog[wcount] = {x_out, y_out, colour};
        wcount++;
      end
      if (done === 1'b1) dcount++;
      if (overflow === 1'b1) ocount++;
    end
  end

  task automatic clr_counts();
    wcount = 0; dcount = 0; ocount = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; it is sampled at the next edge.
  task automatic drive_req(input int x, input int y, input int c, input int f);
    start = 1'b1; x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c); fill_in = 3'(f);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk({nm, "_idle_timeout"}, 1, 0);
  endtask

  typedef struct { int x; int y; int c; int f; int writes; } vec_t;
  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{x:4,   y:4,   c:6, f:0, writes:432};
    tbl[1] = '{x:140, y:112, c:5, f:2, writes:160};
    tbl[2] = '{x:150, y:0,   c:1, f:7, writes:120};
    tbl[3] = '{x:0,   y:115, c:3, f:4, writes:180};
    tbl[4] = '{x:240, y:4,   c:2, f:2, writes:0};
    tbl[5] = '{x:125, y:109, c:7, f:1, writes:385};
    tbl[6] = '{x:250, y:120, c:4, f:6, writes:0};
    tbl[7] = '{x:100, y:100, c:2, f:5, writes:432};

    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_colour", colour, 0);
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);

    // T1: pixel spot checks on a fully visible box
    clr_counts();
    drive_req(4, 4, 6, 0);
    wait_done("t1", n);
    chk("t1_done_latency", n, 432);
    chk("t1_first", wlog[0], {8'd4, 7'd4, 3'd6});
    chk("t1_interior", wlog[37], {8'd5, 7'd5, 3'd0});
    chk("t1_top_right", wlog[35], {8'd39, 7'd4, 3'd6});
    chk("t1_last", wlog[431], {8'd39, 7'd15, 3'd6});
    cyc(1);
    chk("t1_done_width", done, 0);
    chk("t1_hold_x", x_out, 39);
    chk("t1_hold_y", y_out, 15);
    chk("t1_writes", wcount, 432);

    // vector table, including the clipped corners (T4 is entry 1)
    foreach (tbl[i]) begin
      clr_counts();
      drive_req(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].f);
      wait_done("tbl", n);
      chk("tbl_done_latency", n, 432);
      cyc(1);
      chk("tbl_writes", wcount, tbl[i].writes);
      chk("tbl_done_pulses", dcount, 1);
      chk("tbl_idle", busy, 0);
    end

    // T2: second request lands in the pending slot, one DONE cycle between boxes
    clr_counts();
    drive_req(4, 4, 6, 0);
    cyc(9);
    drive_req(44, 4, 3, 1);
    wait_done("t2a", n);
    cyc(1);
    wait_done("t2b", n);
    chk("t2_second_latency", n, 432);
    cyc(1);
    chk("t2_writes", wcount, 864);
    chk("t2_done_pulses", dcount, 2);
    chk("t2_overflows", ocount, 0);

    // T3: third request while pending is full is dropped
    clr_counts();
    drive_req(10, 20, 1, 2);
    cyc(5);
    drive_req(60, 20, 2, 3);
    cyc(5);
    drive_req(100, 50, 4, 5);
    chk("t3_overflow_pulse", overflow, 1);
    cyc(1);
    chk("t3_overflow_clear", overflow, 0);
    wait_idle("t3");
    chk("t3_writes", wcount, 864);
    chk("t3_done_pulses", dcount, 2);
    chk("t3_overflows", ocount, 1);

    // T5: reset mid-draw with a pending request
    clr_counts();
    drive_req(4, 4, 6, 0);
    cyc(3);
    drive_req(50, 50, 1, 1);
    cyc(96);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5_writeEn", writeEn, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    clr_counts();
    cyc(600);
    chk("t5_no_writes", wcount, 0);
    chk("t5_no_done", dcount, 0);

    // T6: start in the DONE cycle while a request is pending
    clr_counts();
    drive_req(4, 4, 6, 0);
    cyc(4);
    drive_req(44, 4, 5, 2);
    wait_done("t6a", n);
    drive_req(84, 4, 3, 7);
    chk("t6_no_overflow", overflow, 0);
    wait_idle("t6");
    chk("t6_writes", wcount, 1296);
    chk("t6_done_pulses", dcount, 3);
    chk("t6_overflows", ocount, 0);

    // random request traffic checked by the model
    for (int i = 0; i < 8000; i++) begin
      start     = ($urandom_range(0, 179) == 0);
      x_in      = 8'($urandom);
      y_in      = 7'($urandom);
      colour_in = 3'($urandom);
      fill_in   = 3'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle("rand");
    chk("rand_model_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
